// File: rtl/board_ram_arbiter.sv
// Board RAM arbiter: registered-grant FSM sharing one single-port RAM among CLR, GAME and VGA,
// with a combinational port mux, an out-of-range address guard and tagged read-reply routing.
module board_ram_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 6,
  parameter int CELLS    = 240,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              clr_wren,
  input  logic [DATA_W-1:0] clr_wdata,
  output logic              clr_gnt,
  input  logic              game_req,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic              game_wren,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_gnt,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              vga_wren,
  input  logic [DATA_W-1:0] vga_wdata,
  output logic              vga_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] rd_data,
  output logic              clr_rd_valid,
  output logic              game_rd_valid,
  output logic              vga_rd_valid,
  output logic              addr_err
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_CLR = 2'd1, OWN_GAME = 2'd2, OWN_VGA = 2'd3} state_t;

  state_t            state, nxt, pick;
  logic              rr_vga;  // 1: VGA goes before GAME at the next arbitration
  logic [HW-1:0]     hold_cnt;
  logic              hold_done;
  logic [ADDR_W-1:0] own_addr;
  logic              own_wren;
  logic [DATA_W-1:0] own_wdata;
  logic              addr_bad, rd_issue;
  logic [RD_LAT:1]       vld_pipe;
  logic [RD_LAT:1][1:0]  id_pipe;

  assign hold_done = (hold_cnt == HW'(MAX_HOLD - 1));

  always_comb begin
    pick = IDLE;
    if (clr_req)        pick = OWN_CLR;
    else if (!rr_vga) begin
      if (game_req)     pick = OWN_GAME;
      else if (vga_req) pick = OWN_VGA;
    end else begin
      if (vga_req)      pick = OWN_VGA;
      else if (game_req) pick = OWN_GAME;
    end
  end

  // While GAME/VGA owns, the pointer already names the other one, so pick hands over correctly.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = pick;
      OWN_CLR:  if (!clr_req) nxt = pick;
      OWN_GAME: if (!game_req || (hold_done && vga_req)) nxt = pick;
      OWN_VGA:  if (!vga_req || (hold_done && game_req)) nxt = pick;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      rr_vga   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state <= nxt;
      if (nxt != state) begin
        hold_cnt <= '0;
        if (nxt == OWN_GAME) rr_vga <= 1'b1;
        if (nxt == OWN_VGA)  rr_vga <= 1'b0;
      end else if ((state == OWN_GAME || state == OWN_VGA) && !hold_done) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    own_addr  = '0;
    own_wren  = 1'b0;
    own_wdata = '0;
    case (state)
      OWN_CLR:  begin own_addr = clr_addr;  own_wren = clr_wren;  own_wdata = clr_wdata;  end
      OWN_GAME: begin own_addr = game_addr; own_wren = game_wren; own_wdata = game_wdata; end
      OWN_VGA:  begin own_addr = vga_addr;  own_wren = vga_wren;  own_wdata = vga_wdata;  end
      default:  ;
    endcase
  end

  assign addr_bad = (state != IDLE) && (own_addr >= ADDR_W'(CELLS));
  assign rd_issue = (state != IDLE) && !own_wren && !addr_bad;
  assign ram_addr = own_addr;
  assign ram_wren = own_wren && !addr_bad;
  assign ram_data = own_wdata;
  assign rd_data  = ram_q;

  assign clr_gnt  = (state == OWN_CLR);
  assign game_gnt = (state == OWN_GAME);
  assign vga_gnt  = (state == OWN_VGA);

  // Issuer id travels with the read so the reply finds it even after the grant moves.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
      addr_err <= 1'b0;
    end else begin
      vld_pipe[1] <= rd_issue;
      id_pipe[1]  <= state;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
      if (addr_bad) addr_err <= 1'b1;
    end
  end

  assign clr_rd_valid  = vld_pipe[RD_LAT] && (id_pipe[RD_LAT] == OWN_CLR);
  assign game_rd_valid = vld_pipe[RD_LAT] && (id_pipe[RD_LAT] == OWN_GAME);
  assign vga_rd_valid  = vld_pipe[RD_LAT] && (id_pipe[RD_LAT] == OWN_VGA);

endmodule
